// File: rtl/jtframe_tilemap_linebuf.sv
// jtframe_tilemap_linebuf: ping-pong line buffer between the 8x8 tilemap renderer and the mixer.
// Optional horizontal scroll latch built only with JTFRAME_TILEMAP_HSCROLL_EN defined.
module jtframe_tilemap_linebuf #(
  parameter int DW = 11,
  parameter int AW = 9,
  parameter logic [DW-1:0] BLANK = '0
)(
  input  logic          rst,
  input  logic          clk,
  input  logic          pxl_cen_i,
  input  logic          lhbl_i,
  input  logic          lvbl_i,
  input  logic [8:0]    hdump_i,
  input  logic [8:0]    hpos_i,
  input  logic          flip_i,
  output logic          start_o,
  output logic          stop_o,
  input  logic          done_i,
  input  logic [AW-1:0] buf_addr_i,
  input  logic [DW-1:0] buf_data_i,
  input  logic          buf_wr_i,
  output logic [DW-1:0] pxl_o,
  output logic          overrun_o
);
  typedef enum logic [1:0] {IDLE, SWAP, START, BUSY} state_t;
  state_t state_q, state_d;
  logic rd_bank_q, rd_bank_d, from_busy_q, from_busy_d, overrun_q, overrun_d;
  logic lhbl_q, blank_q, blk2_q, line_ev, wr_en, unused;
  logic [7:0] hscr, col, rd_addr, addr_q;
  logic [DW-1:0] ram_q, pxl_q;
  logic [DW-1:0] mem [0:511];

  assign line_ev = lhbl_q & ~lhbl_i;
  assign wr_en   = buf_wr_i & ~|buf_addr_i[AW-1:8];
  assign col     = flip_i ? ~hdump_i[7:0] : hdump_i[7:0];
  assign rd_addr = col + hscr;
  assign pxl_o     = pxl_q;
  assign overrun_o = overrun_q;
  assign unused    = ^{hdump_i[8], hpos_i};

`ifdef JTFRAME_TILEMAP_HSCROLL_EN
  logic [7:0] hscr_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) hscr_q <= '0;
    else if (line_ev) hscr_q <= hpos_i[7:0];
  assign hscr = hscr_q;
`else
  assign hscr = '0;
`endif

  always_comb begin
    state_d     = state_q;
    rd_bank_d   = rd_bank_q;
    from_busy_d = from_busy_q;
    overrun_d   = overrun_q;
    start_o     = 1'b0;
    stop_o      = 1'b0;
    case (state_q)
      IDLE: if (line_ev) begin
        state_d     = SWAP;
        from_busy_d = 1'b0;
      end
      SWAP: begin
        rd_bank_d = ~rd_bank_q;
        stop_o    = from_busy_q;
        overrun_d = overrun_q | from_busy_q;
        state_d   = START;
      end
      START: begin
        start_o = 1'b1;
        state_d = BUSY;
      end
      BUSY: if (done_i) state_d = IDLE;
        else if (line_ev) begin
          state_d     = SWAP;
          from_busy_d = 1'b1;
        end
    endcase
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q     <= IDLE;
      rd_bank_q   <= 1'b0;
      from_busy_q <= 1'b0;
      overrun_q   <= 1'b0;
      lhbl_q      <= 1'b0;
      addr_q      <= '0;
      blank_q     <= 1'b1;
      blk2_q      <= 1'b1;
      pxl_q       <= BLANK;
    end else begin
      state_q     <= state_d;
      rd_bank_q   <= rd_bank_d;
      from_busy_q <= from_busy_d;
      overrun_q   <= overrun_d;
      lhbl_q      <= lhbl_i;
      if (pxl_cen_i) begin
        addr_q  <= rd_addr;
        blank_q <= ~(lhbl_i & lvbl_i);
      end
      blk2_q <= blank_q;
      pxl_q  <= blk2_q ? BLANK : ram_q;
    end

  // Write side uses the bank not being displayed; the read lags the address register by one clk
  always_ff @(posedge clk) begin
    if (wr_en) mem[{~rd_bank_q, buf_addr_i[7:0]}] <= buf_data_i;
    ram_q <= mem[{rd_bank_q, addr_q}];
  end
endmodule

// File: tb/tb_jtframe_tilemap_linebuf.sv
// tb_jtframe_tilemap_linebuf: directed, table-driven bench for the tilemap line buffer.
module tb_jtframe_tilemap_linebuf;
  logic rst = 1'b1, clk = 1'b0, pxl_cen = 1'b0, lhbl = 1'b1, lvbl = 1'b1, flip = 1'b0;
  logic done = 1'b0, buf_wr = 1'b0, start, stop, overrun;
  logic [8:0] hdump = '0, hpos = '0, buf_addr = '0;
  logic [10:0] buf_data = '0, pxl;
  int n_chk = 0, n_fail = 0;

  typedef struct {
    logic [8:0]  hd;
    logic        fl;
    logic        vb;
    logic [10:0] exp;
    string       nm;
  } vec_t;
  vec_t vecs[8];

  jtframe_tilemap_linebuf dut (
    .rst(rst), .clk(clk), .pxl_cen_i(pxl_cen), .lhbl_i(lhbl), .lvbl_i(lvbl),
    .hdump_i(hdump), .hpos_i(hpos), .flip_i(flip), .start_o(start), .stop_o(stop),
    .done_i(done), .buf_addr_i(buf_addr), .buf_data_i(buf_data), .buf_wr_i(buf_wr),
    .pxl_o(pxl), .overrun_o(overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [10:0] act, input logic [10:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic rd(input logic [8:0] hd, input logic fl, input logic vb,
                    input logic [10:0] exp, input string nm);
    @(negedge clk); hdump = hd; flip = fl; lvbl = vb; pxl_cen = 1'b1;
    @(negedge clk); pxl_cen = 1'b0;
    @(negedge clk);
    @(negedge clk); chk(nm, pxl, exp); lvbl = 1'b1; flip = 1'b0;
  endtask

  task automatic line_event(input logic exp_stop, input string nm);
    @(negedge clk); lhbl = 1'b0; hdump = 9'd7; pxl_cen = 1'b1;
    @(negedge clk); pxl_cen = 1'b0;
    chk({nm, " swap start"}, 11'(start), 11'd0);
    chk({nm, " swap stop"}, 11'(stop), 11'(exp_stop));
    @(negedge clk);
    chk({nm, " start pulse"}, 11'(start), 11'd1);
    chk({nm, " start stop"}, 11'(stop), 11'd0);
    @(negedge clk);
    chk({nm, " start end"}, 11'(start), 11'd0);
    chk({nm, " hblank pxl"}, pxl, 11'd0);
    lhbl = 1'b1;
  endtask

  task automatic pulse_done;
    @(negedge clk); done = 1'b1;
    @(negedge clk); done = 1'b0;
  endtask

  task automatic fill(input logic hi);
    for (int a = 0; a < 256; a++) begin
      @(negedge clk); buf_addr = 9'(a); buf_data = {hi, 2'b00, 8'(a)}; buf_wr = 1'b1;
    end
    @(negedge clk); buf_wr = 1'b0;
  endtask

  initial begin
    vecs[0] = '{9'h000, 1'b0, 1'b1, 11'h000, "h000"};
    vecs[1] = '{9'h005, 1'b0, 1'b1, 11'h005, "h005"};
    vecs[2] = '{9'h0FF, 1'b0, 1'b1, 11'h0FF, "h0ff"};
    vecs[3] = '{9'h180, 1'b0, 1'b1, 11'h080, "hdump bit8"};
    vecs[4] = '{9'h000, 1'b1, 1'b1, 11'h0FF, "flip h000"};
    vecs[5] = '{9'h010, 1'b1, 1'b1, 11'h0EF, "flip h010"};
    vecs[6] = '{9'h007, 1'b0, 1'b0, 11'h000, "vblank"};
    vecs[7] = '{9'h007, 1'b0, 1'b1, 11'h007, "after vblank"};
    repeat (3) @(negedge clk);
    chk("reset start", 11'(start), 11'd0);
    chk("reset stop", 11'(stop), 11'd0);
    chk("reset pxl", pxl, 11'd0);
    chk("reset overrun", 11'(overrun), 11'd0);
    rst = 1'b0;
    fill(1'b0);
    line_event(1'b0, "ev1");
    pulse_done;
    chk("ev1 overrun", 11'(overrun), 11'd0);
    fill(1'b1);
    @(negedge clk); buf_addr = 9'h100; buf_data = 11'h7FF; buf_wr = 1'b1;
    @(negedge clk); buf_wr = 1'b0;
    for (int a = 0; a < 256; a++) rd(9'(a), 1'b0, 1'b1, 11'(a), "sweep");
    foreach (vecs[i]) rd(vecs[i].hd, vecs[i].fl, vecs[i].vb, vecs[i].exp, vecs[i].nm);
    line_event(1'b0, "ev2");
    rd(9'h000, 1'b0, 1'b1, 11'h400, "eol write bank0 h000");
    rd(9'h080, 1'b0, 1'b1, 11'h480, "bank0 h080");
    line_event(1'b1, "ev3 overrun");
    chk("overrun set", 11'(overrun), 11'd1);
    rd(9'h000, 1'b0, 1'b1, 11'h000, "bank1 after overrun");
    pulse_done;
    chk("overrun sticky", 11'(overrun), 11'd1);
    hpos = 9'h0F0;
    line_event(1'b0, "ev4");
    pulse_done;
    hpos = 9'h000;
    chk("overrun still sticky", 11'(overrun), 11'd1);
`ifdef JTFRAME_TILEMAP_HSCROLL_EN
    rd(9'h020, 1'b0, 1'b1, 11'h410, "scroll h020");
`else
    rd(9'h020, 1'b0, 1'b1, 11'h420, "scroll ignored h020");
`endif
    @(negedge clk); lhbl = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("ev5 start before reset", 11'(start), 11'd1);
    rst = 1'b1; lhbl = 1'b1;
    #1;
    chk("mid-line reset start", 11'(start), 11'd0);
    chk("mid-line reset stop", 11'(stop), 11'd0);
    chk("mid-line reset pxl", pxl, 11'd0);
    chk("mid-line reset overrun", 11'(overrun), 11'd0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("idle after reset", 11'(start), 11'd0);
    rd(9'h003, 1'b0, 1'b1, 11'h403, "bank0 after reset");
    line_event(1'b0, "ev6");
    chk("ev6 overrun", 11'(overrun), 11'd0);
    rd(9'h003, 1'b0, 1'b1, 11'h003, "bank1 after ev6");
    pulse_done;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
